// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM issuing fetch/decode/execute datapath strobes with a memory wait timeout.
module control_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mem_ready,
  input  logic [5:0] opcode,
  output logic       loadIR,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_we,
  output logic [3:0] alu_op,
  output logic       busy,
  output logic       halted,
  output logic       fault,
  output logic [7:0] instr_count,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD_IR, DECODE, EXEC_ALU, EXEC_MEM, WB, EXEC_BR, HALT, FAULT
  } state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t          r_state, w_next;
  logic [CW-1:0]   r_wait;
  logic [5:0]      r_op;
  logic [7:0]      r_cnt;
  logic            w_wait, w_tmo, w_load;
  assign w_wait = (r_state == FETCH || r_state == EXEC_MEM) && !mem_ready;
  assign w_tmo  = w_wait && (r_wait == CW'(TIMEOUT - 1));
  assign w_load = r_op[5:4] == 2'b01;
  // Opcode is captured in DECODE so execute states decode from registers only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait ? r_wait + 1'b1 : '0;
      if (r_state == DECODE) r_op <= opcode;
      if (r_state == LOAD_IR) r_cnt <= r_cnt + 1'b1;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = start ? FETCH : IDLE;
      FETCH:    w_next = w_tmo ? FAULT : mem_ready ? LOAD_IR : FETCH;
      LOAD_IR:  w_next = DECODE;
      DECODE:   w_next = opcode == 6'b000000 ? FETCH :
                         &opcode ? HALT :
                         opcode[5:4] == 2'b00 ? EXEC_ALU :
                         opcode[5:4] == 2'b11 ? EXEC_BR : EXEC_MEM;
      EXEC_ALU: w_next = FETCH;
      EXEC_MEM: w_next = w_tmo ? FAULT : mem_ready ? (w_load ? WB : FETCH) : EXEC_MEM;
      WB:       w_next = FETCH;
      EXEC_BR:  w_next = FETCH;
      HALT:     w_next = HALT;
      FAULT:    w_next = FAULT;
      default:  w_next = IDLE;
    endcase
  end
  assign loadIR      = r_state == LOAD_IR;
  assign pc_inc      = r_state == LOAD_IR;
  assign pc_load     = r_state == EXEC_BR;
  assign mem_rd      = r_state == FETCH || (r_state == EXEC_MEM && w_load);
  assign mem_wr      = r_state == EXEC_MEM && r_op[5:4] == 2'b10;
  assign reg_we      = r_state == EXEC_ALU || r_state == WB;
  assign alu_op      = r_state == EXEC_ALU ? r_op[3:0] : 4'd0;
  assign busy        = r_state inside {FETCH, LOAD_IR, DECODE, EXEC_ALU, EXEC_MEM, WB, EXEC_BR};
  assign halted      = r_state == HALT;
  assign fault       = r_state == FAULT;
  assign instr_count = r_cnt;
  assign state       = r_state;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: builds per-instruction expected cycle traces from the instruction rules and replays them.
module tb_control_sequencer;
  localparam int TO = 15;
  logic clk = 0, rst_n = 0, start = 0, mem_ready = 0;
  logic [5:0] opcode = 0;
  logic loadIR, pc_inc, pc_load, mem_rd, mem_wr, reg_we, busy, halted, fault;
  logic [3:0] alu_op, state;
  logic [7:0] instr_count;
  control_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_ready(mem_ready), .opcode(opcode),
    .loadIR(loadIR), .pc_inc(pc_inc), .pc_load(pc_load), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .reg_we(reg_we), .alu_op(alu_op), .busy(busy), .halted(halted), .fault(fault),
    .instr_count(instr_count), .state(state)
  );
  always #5 clk = ~clk;
  // Expected output word: loadIR pc_inc pc_load mem_rd mem_wr reg_we alu_op[3:0] busy halted fault
  localparam logic [12:0] E_IDLE  = 13'b0_0_0_0_0_0_0000_0_0_0;
  localparam logic [12:0] E_FETCH = 13'b0_0_0_1_0_0_0000_1_0_0;
  localparam logic [12:0] E_LIR   = 13'b1_1_0_0_0_0_0000_1_0_0;
  localparam logic [12:0] E_DEC   = 13'b0_0_0_0_0_0_0000_1_0_0;
  localparam logic [12:0] E_WR    = 13'b0_0_0_0_1_0_0000_1_0_0;
  localparam logic [12:0] E_WB    = 13'b0_0_0_0_0_1_0000_1_0_0;
  localparam logic [12:0] E_BR    = 13'b0_0_1_0_0_0_0000_1_0_0;
  localparam logic [12:0] E_HALT  = 13'b0_0_0_0_0_0_0000_0_1_0;
  localparam logic [12:0] E_FLT   = 13'b0_0_0_0_0_0_0000_0_0_1;
  typedef struct packed {
    logic rst, st, mr;
    logic [5:0] op;
    logic chk;
    logic [12:0] exp;
    logic [7:0] cnt;
  } ent_t;
  ent_t q[$];
  logic [5:0] cur_op = 0;
  logic [7:0] cnt = 0;
  int n_vec = 0, n_err = 0;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic push(input logic r, input logic s, input logic m, input logic c, input logic [12:0] e);
    q.push_back('{r, s, m, cur_op, c, e, cnt});
  endtask
  task automatic do_reset();
    push(1, rb(), rb(), 0, E_IDLE);
    push(1, rb(), rb(), 0, E_IDLE);
    cnt = 0;
  endtask
  task automatic start_seq();
    for (int i = 0; i < 3; i++) push(0, 0, rb(), 1, E_IDLE);
    push(0, 1, rb(), 1, E_IDLE);
  endtask
  task automatic mwait(input logic [12:0] e, input int n, output bit flt);
    flt = n >= TO;
    for (int i = 0; i < n && i < TO; i++) push(0, rb(), 0, 1, e);
    if (!flt) push(0, rb(), 1, 1, e);
  endtask
  task automatic tail(input logic [12:0] e);
    for (int i = 0; i < 6; i++) push(0, rb() | (i == 2), rb(), 1, e);
  endtask
  // One instruction: fw/mw are memory wait cycles, rc>=0 asserts reset after rc EXEC_MEM waits
  task automatic instr(input logic [5:0] op, input int fw, input int mw, input int rc);
    bit f;
    logic [12:0] me;
    cur_op = op;
    mwait(E_FETCH, fw, f);
    if (f) begin tail(E_FLT); return; end
    push(0, rb(), rb(), 1, E_LIR);
    cnt++;
    push(0, rb(), rb(), 1, E_DEC);
    if (op == 6'd0) return;
    if (op == 6'h3f) begin tail(E_HALT); return; end
    me = op[5:4] == 2'b01 ? E_FETCH : E_WR;
    case (op[5:4])
      2'b00: push(0, rb(), rb(), 1, {6'b000001, op[3:0], 3'b100});
      2'b11: push(0, rb(), rb(), 1, E_BR);
      default: begin
        if (rc >= 0) begin
          for (int i = 0; i < rc; i++) push(0, rb(), 0, 1, me);
          push(1, rb(), rb(), 1, me);
          cnt = 0;
          return;
        end
        mwait(me, mw, f);
        if (f) tail(E_FLT);
        else if (op[5:4] == 2'b01) push(0, rb(), rb(), 1, E_WB);
      end
    endcase
  endtask
  initial begin
    logic [5:0] op;
    int fw, mw;
    do_reset(); start_seq();
    instr(6'b000101, 0, 0, -1);
    instr(6'b010000, 0, 3, -1);
    instr(6'b100111, 0, 2, -1);
    instr(6'b110000, 0, 0, -1);
    instr(6'b000000, 0, 0, -1);
    instr(6'b001010, TO - 1, 0, -1);
    instr(6'b010001, 0, TO - 1, -1);
    instr(6'b101100, 2, TO - 1, -1);
    for (int k = 0; k < 150; k++) begin
      op = 6'($urandom);
      if (op == 6'h3f) op = 6'h3e;
      fw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
      instr(op, fw, mw, -1);
    end
    do_reset(); start_seq();
    for (int k = 0; k < 256; k++) instr(6'd0, 0, 0, -1);
    instr(6'b000011, 0, 0, -1);
    instr(6'b010010, 1, 0, 2);
    start_seq();
    instr(6'b000110, 0, 0, -1);
    instr(6'h3f, 0, 0, -1);
    do_reset(); start_seq();
    instr(6'd0, TO + 3, 0, -1);
    do_reset(); start_seq();
    instr(6'b100000, 0, TO, -1);
    do_reset(); start_seq();
    instr(6'b010101, 0, 1, -1);
    foreach (q[i]) begin
      @(negedge clk);
      rst_n = !q[i].rst;
      start = q[i].st;
      mem_ready = q[i].mr;
      opcode = q[i].op;
      if (q[i].chk) begin
        check("outs", {3'b0, loadIR, pc_inc, pc_load, mem_rd, mem_wr, reg_we, alu_op, busy, halted, fault}, {3'b0, q[i].exp});
        check("instr_count", {8'b0, instr_count}, {8'b0, q[i].cnt});
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles FETCH/MEM states wait for mem_ready before fault.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port start  input  1  leave IDLE and begin fetching.
REQ-005 SHALL have port mem_ready  input  1  memory completes current read/write this cycle.
REQ-006 SHALL have port opcode  input  6  current instruction from IR output.
REQ-007 SHALL have ports loadIR, pc_inc, pc_load, mem_rd, mem_wr, reg_we  output  1 each  datapath strobes.
REQ-008 SHALL have port alu_op  output  4  ALU function; equals opcode[3:0] in EXEC_ALU, else 0.
REQ-009 SHALL have ports busy, halted, fault  output  1 each  status.
REQ-010 SHALL have port instr_count  output  8  instructions loaded since reset.
REQ-011 SHALL have port state  output  4  current state encoding, for debug.

Function
REQ-012 SHALL be a Moore FSM; strobes and status decode from registered state only.
REQ-013 SHALL implement states IDLE, FETCH, LOAD_IR, DECODE, EXEC_ALU, EXEC_MEM, WB, EXEC_BR, HALT, FAULT.
REQ-014 IDLE: all strobes 0, busy 0; start=1 -> FETCH next cycle, else stay.
REQ-015 FETCH: mem_rd=1, busy=1; mem_ready=1 -> LOAD_IR; held in FETCH while mem_ready=0.
REQ-016 LOAD_IR: loadIR=1 and pc_inc=1 for exactly one cycle; instr_count increments (255 wraps to 0); -> DECODE.
REQ-017 DECODE: one cycle, no strobes; opcode sampled here selects next state.
REQ-018 Decode: 6'b000000 (NOP) -> FETCH; 6'b111111 -> HALT; else opcode[5:4]=00 -> EXEC_ALU, 01 (LOAD) or 10 (STORE) -> EXEC_MEM, 11 -> EXEC_BR.
REQ-019 EXEC_ALU: reg_we=1, alu_op=opcode[3:0], one cycle -> FETCH.
REQ-020 EXEC_MEM: mem_rd=1 for LOAD, mem_wr=1 for STORE, held until mem_ready=1; then LOAD -> WB, STORE -> FETCH.
REQ-021 WB: reg_we=1 one cycle -> FETCH.
REQ-022 EXEC_BR: pc_load=1 one cycle, pc_inc=0 -> FETCH.
REQ-023 HALT: halted=1, busy=0, no strobes; start ignored; exit only by reset.
REQ-024 Wait counter SHALL clear on entry to FETCH/EXEC_MEM and increment each cycle mem_ready=0 there; reaching TIMEOUT -> FAULT.
REQ-025 FAULT: fault=1, busy=0, no strobes; exit only by reset.
REQ-026 mem_ready outside FETCH/EXEC_MEM SHALL be ignored.
REQ-027 mem_rd and mem_wr SHALL never both be 1; loadIR, pc_load, reg_we SHALL never be 1 in the same cycle.
REQ-028 Minimum latency per instruction (mem_ready=1 immediately): ALU 4 cycles, LOAD 5, STORE 4, BR 4, NOP 3 (FETCH to next FETCH).

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE, instr_count=0, wait counter=0, all outputs 0, from any state including mid-wait, HALT, FAULT.
REQ-030 Reset SHALL take priority over start, mem_ready, and every transition in the same cycle.
REQ-031 After rst_n returns 1, block SHALL stay in IDLE until start=1.

Verification
REQ-032 Reset, start=1, mem_ready=1, opcode=6'b000101 -> FETCH,LOAD_IR,DECODE,EXEC_ALU; reg_we=1 with alu_op=4'b0101 in cycle 4; instr_count=1.
REQ-033 LOAD opcode=6'b010000, mem_ready low 3 cycles in EXEC_MEM -> mem_rd held 4 cycles, then WB with reg_we=1 one cycle, then FETCH.
REQ-034 opcode=6'b110000 -> pc_load=1 exactly one cycle, pc_inc=0 that cycle; opcode=6'b111111 -> halted=1 stays with start pulsed.
REQ-035 mem_ready held 0 in FETCH with TIMEOUT=15 -> FAULT after 15 wait cycles, fault=1, mem_rd=0.
REQ-036 256 NOPs from reset -> instr_count wraps to 0; rst_n=0 during EXEC_MEM -> IDLE, all outputs 0 next cycle.
